// File: rtl/ser_grid_pkg.sv
// Shared types and defaults for the output sequencer slice.
package ser_grid_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StFin
  } seq_state_e;

endpackage

// File: rtl/ch_ptr.sv
// Channel pointer helper: wrap-around increment (step=1) or range clamp (step=0).
module ch_ptr #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] cur,
  input  logic             step,
  output logic [SEL_W-1:0] nxt
);

  localparam logic [SEL_W-1:0] Last = SEL_W'(N_CH - 1);

  always_comb begin
    nxt = cur;
    if (step) begin
      nxt = (cur >= Last) ? '0 : cur + SEL_W'(1);
    end else begin
      nxt = (cur > Last) ? Last : cur;
    end
  end

endmodule

// File: rtl/output_sequencer.sv
// Presents one channel of neuron output to the SPI side: either a live direct
// selection or a handshaked scan over a snapshot of all channels.
module output_sequencer
  import ser_grid_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned N_CH   = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] dout_flat,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       output_select,
  input  logic [SEL_W-1:0]       start_ch,
  input  logic [SEL_W-1:0]       end_ch,
  input  logic                   snap_req,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      dout_spi,
  output logic                   out_valid,
  output logic [SEL_W-1:0]       out_idx,
  output logic                   busy,
  output logic                   done
);

  seq_state_e        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  end_q, end_d;
  logic [DATA_W-1:0] shadow_q [N_CH];
  logic [DATA_W-1:0] shadow_d [N_CH];
  logic [DATA_W-1:0] live_ch  [N_CH];
  logic [DATA_W-1:0] dout_spi_q, dout_spi_d;
  logic [SEL_W-1:0]  out_idx_q, out_idx_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SEL_W-1:0]  ptr_nxt, start_cl, end_cl;
  logic              sel_ok;

  ch_ptr #(.N_CH(N_CH), .SEL_W(SEL_W)) u_ptr_inc (
    .cur  (ptr_q),
    .step (1'b1),
    .nxt  (ptr_nxt)
  );

  ch_ptr #(.N_CH(N_CH), .SEL_W(SEL_W)) u_start_clamp (
    .cur  (start_ch),
    .step (1'b0),
    .nxt  (start_cl)
  );

  ch_ptr #(.N_CH(N_CH), .SEL_W(SEL_W)) u_end_clamp (
    .cur  (end_ch),
    .step (1'b0),
    .nxt  (end_cl)
  );

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      live_ch[k] = dout_flat[k*DATA_W +: DATA_W];
    end
  end

  assign sel_ok = ({1'b0, output_select} < (SEL_W + 1)'(N_CH));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    shadow_d    = shadow_q;
    dout_spi_d  = dout_spi_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mode && snap_req) begin
          // Snapshot and first beat load on the same edge.
          shadow_d    = live_ch;
          ptr_d       = start_cl;
          end_d       = end_cl;
          dout_spi_d  = live_ch[start_cl];
          out_idx_d   = start_cl;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = StSend;
        end else begin
          dout_spi_d  = sel_ok ? live_ch[output_select] : '0;
          out_idx_d   = output_select;
          out_valid_d = 1'b0;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (ptr_q == end_q) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = StFin;
          end else begin
            ptr_d      = ptr_nxt;
            dout_spi_d = shadow_q[ptr_nxt];
            out_idx_d  = ptr_nxt;
          end
        end
      end
      StFin: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      end_q       <= '0;
      shadow_q    <= '{default: '0};
      dout_spi_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      shadow_q    <= shadow_d;
      dout_spi_q  <= dout_spi_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dout_spi  = dout_spi_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_output_sequencer.sv
// Scoreboard bench: stimulus pushes expected scan beats, a monitor pops them on handshakes.
module tb_output_sequencer;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } beat_t;

  logic        clk;
  logic        rst_n;
  // N_CH = 8 instance
  logic [63:0] a_flat;
  logic        a_mode, a_snap, a_ready;
  logic [2:0]  a_sel, a_start, a_end;
  logic [7:0]  a_dout;
  logic        a_valid, a_busy, a_done;
  logic [2:0]  a_idx;
  // N_CH = 6 instance
  logic [47:0] b_flat;
  logic        b_mode, b_snap, b_ready;
  logic [2:0]  b_sel, b_start, b_end;
  logic [7:0]  b_dout;
  logic        b_valid, b_busy, b_done;
  logic [2:0]  b_idx;

  int    checks = 0;
  int    errors = 0;
  int    beat_cnt = 0;
  int    cyc;
  beat_t exp_q[$];

  output_sequencer #(.DATA_W(8), .N_CH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .dout_flat(a_flat), .mode(a_mode),
    .output_select(a_sel), .start_ch(a_start), .end_ch(a_end), .snap_req(a_snap),
    .out_ready(a_ready), .dout_spi(a_dout), .out_valid(a_valid), .out_idx(a_idx),
    .busy(a_busy), .done(a_done)
  );

  output_sequencer #(.DATA_W(8), .N_CH(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .dout_flat(b_flat), .mode(b_mode),
    .output_select(b_sel), .start_ch(b_start), .end_ch(b_end), .snap_req(b_snap),
    .out_ready(b_ready), .dout_spi(b_dout), .out_valid(b_valid), .out_idx(b_idx),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [2:0] idx, input logic [7:0] data);
    beat_t b;
    b.idx  = idx;
    b.data = data;
    exp_q.push_back(b);
  endtask

  // Counts negedges until done is seen; an expired budget is a failure.
  task automatic wait_done(input int max, output int n);
    bit seen = 0;
    n = 0;
    while (!seen && n < max) begin
      @(negedge clk);
      n++;
      if (a_done) seen = 1;
    end
    if (!seen) check("done_timeout", 32'(n), 32'(max + 1));
  endtask

  task automatic set_flat_a(input logic [7:0] base);
    for (int k = 0; k < 8; k++) a_flat[k*8 +: 8] = base + 8'(k);
  endtask

  // Monitor: a beat completes on the edge after valid && ready is seen here.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && a_valid && a_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {21'd0, a_idx, a_dout}, 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          check("beat_idx", 32'(a_idx), 32'(b.idx));
          check("beat_data", 32'(a_dout), 32'(b.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int bc0;
    logic [2:0] prev;
    rst_n = 0;
    a_flat = '0; a_mode = 0; a_snap = 0; a_ready = 1; a_sel = 0; a_start = 0; a_end = 0;
    b_flat = '0; b_mode = 0; b_snap = 0; b_ready = 1; b_sel = 0; b_start = 0; b_end = 0;
    set_flat_a(8'h10);
    for (int k = 0; k < 6; k++) b_flat[k*8 +: 8] = 8'h20 + 8'(k);
    a_sel = 3'd5;
    tick();
    tick();
    check("rst_dout", 32'(a_dout), 0);
    check("rst_idx", 32'(a_idx), 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    rst_n = 1;
    tick();

    // Direct mode
    a_sel = 3'd5;
    tick();
    check("direct5_dout", 32'(a_dout), 32'h15);
    check("direct5_idx", 32'(a_idx), 5);
    check("direct5_valid", 32'(a_valid), 0);
    a_sel = 3'd0;
    tick();
    check("direct0_dout", 32'(a_dout), 32'h10);
    a_sel = 3'd7;
    tick();
    check("direct7_dout", 32'(a_dout), 32'h17);

    // snap_req in direct mode is ignored
    a_snap = 1;
    tick();
    a_snap = 0;
    check("snap_mode0_busy", 32'(a_busy), 0);
    check("snap_mode0_valid", 32'(a_valid), 0);

    // Scan 2..4
    a_mode = 1; a_start = 3'd2; a_end = 3'd4; a_ready = 1;
    push_beat(3'd2, 8'h12); push_beat(3'd3, 8'h13); push_beat(3'd4, 8'h14);
    a_snap = 1;
    tick();
    a_snap = 0;
    check("scan_busy", 32'(a_busy), 1);
    wait_done(20, cyc);
    check("scan_done_cycle", 32'(cyc), 4);
    check("scan_fin_busy", 32'(a_busy), 1);
    check("scan_q_empty", 32'(exp_q.size()), 0);
    @(negedge clk);
    check("scan_done_pulse", 32'(a_done), 0);
    check("scan_idle_busy", 32'(a_busy), 0);

    // Wrap 6..1 with live data changed after capture
    a_start = 3'd6; a_end = 3'd1;
    push_beat(3'd6, 8'h16); push_beat(3'd7, 8'h17); push_beat(3'd0, 8'h10);
    push_beat(3'd1, 8'h11);
    a_snap = 1;
    tick();
    a_snap = 0;
    set_flat_a(8'hA0);
    wait_done(20, cyc);
    check("wrap_done_cycle", 32'(cyc), 5);
    check("wrap_q_empty", 32'(exp_q.size()), 0);
    set_flat_a(8'h10);
    tick();

    // Single beat, start == end
    a_start = 3'd5; a_end = 3'd5;
    push_beat(3'd5, 8'h15);
    a_snap = 1;
    tick();
    a_snap = 0;
    wait_done(20, cyc);
    check("single_done_cycle", 32'(cyc), 2);
    check("single_q_empty", 32'(exp_q.size()), 0);
    tick();

    // Backpressure: ready alternates 1/0 starting after capture
    a_start = 3'd2; a_end = 3'd4; a_ready = 0;
    push_beat(3'd2, 8'h12); push_beat(3'd3, 8'h13); push_beat(3'd4, 8'h14);
    bc0 = beat_cnt;
    a_snap = 1;
    tick();
    a_snap = 0;
    for (int i = 0; i < 5; i++) begin
      a_ready = (i % 2 == 0);
      prev = a_idx;
      tick();
      if (!a_ready) check("bp_hold_idx", 32'(a_idx), 32'(prev));
    end
    check("bp_done", 32'(a_done), 1);
    check("bp_beats", 32'(beat_cnt - bc0), 3);
    check("bp_q_empty", 32'(exp_q.size()), 0);
    a_ready = 1;
    tick();

    // snap while busy ignored; start/end/mode changes mid-scan ignored
    a_start = 3'd2; a_end = 3'd4;
    push_beat(3'd2, 8'h12); push_beat(3'd3, 8'h13); push_beat(3'd4, 8'h14);
    a_snap = 1;
    tick();
    a_start = 3'd0; a_end = 3'd7; a_mode = 0;
    tick();
    a_snap = 0;
    wait_done(20, cyc);
    check("busy_snap_done_cycle", 32'(cyc), 3);
    check("busy_snap_q_empty", 32'(exp_q.size()), 0);
    @(negedge clk);
    check("busy_snap_idle", 32'(a_busy), 0);
    a_mode = 1;
    tick();

    // Reset mid-scan after one beat
    a_start = 3'd1; a_end = 3'd3;
    push_beat(3'd1, 8'h11);
    a_snap = 1;
    tick();
    a_snap = 0;
    tick();
    rst_n = 0;
    #1;
    check("mid_rst_dout", 32'(a_dout), 0);
    check("mid_rst_idx", 32'(a_idx), 0);
    check("mid_rst_valid", 32'(a_valid), 0);
    check("mid_rst_busy", 32'(a_busy), 0);
    check("mid_rst_q_empty", 32'(exp_q.size()), 0);
    tick();
    rst_n = 1;
    repeat (2) begin
      tick();
      check("post_rst_no_done", 32'(a_done), 0);
      check("post_rst_busy", 32'(a_busy), 0);
    end
    push_beat(3'd1, 8'h11); push_beat(3'd2, 8'h12); push_beat(3'd3, 8'h13);
    a_snap = 1;
    tick();
    a_snap = 0;
    check("restart_idx", 32'(a_idx), 1);
    wait_done(20, cyc);
    check("restart_done_cycle", 32'(cyc), 4);
    check("restart_q_empty", 32'(exp_q.size()), 0);
    tick();

    // N_CH = 6 instance: out-of-range select and clamped single-beat scan
    b_mode = 0; b_sel = 3'd7;
    tick();
    check("b_sel7_dout", 32'(b_dout), 0);
    b_sel = 3'd3;
    tick();
    check("b_sel3_dout", 32'(b_dout), 32'h23);
    b_mode = 1; b_start = 3'd7; b_end = 3'd7;
    b_snap = 1;
    tick();
    b_snap = 0;
    check("b_clamp_valid", 32'(b_valid), 1);
    check("b_clamp_idx", 32'(b_idx), 5);
    check("b_clamp_dout", 32'(b_dout), 32'h25);
    tick();
    check("b_clamp_done", 32'(b_done), 1);
    check("b_clamp_valid_end", 32'(b_valid), 0);
    tick();
    check("b_clamp_done_end", 32'(b_done), 0);
    check("b_clamp_busy_end", 32'(b_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_sequencer.md
OUTPUT_SEQUENCER -- requirements
Module: output_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be as follows:
- DATA_W, 8, neuron output width.
- N_CH, 8, channel count (2..64, power of two not required).
- SEL_W, $clog2(N_CH), select/index width.
REQ-002 Ports (name, direction, width, meaning) SHALL be as follows:
- clk, in, 1, single clock, all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- dout_flat, in, N_CH*DATA_W, channel k occupies bits [k*DATA_W +: DATA_W].
- mode, in, 1, 0 = direct select, 1 = scan.
- output_select, in, SEL_W, direct-mode channel index.
- start_ch, in, SEL_W, first scan channel.
- end_ch, in, SEL_W, last scan channel.
- snap_req, in, 1, one-cycle pulse that starts a scan.
- out_ready, in, 1, SPI side ready.
- dout_spi, out, DATA_W, output byte.
- out_valid, out, 1, dout_spi valid (scan mode).
- out_idx, out, SEL_W, channel index of dout_spi.
- busy, out, 1, scan in progress.
- done, out, 1, one-cycle pulse after the last scan beat.

Function
REQ-003 Direct mode (mode=0, FSM IDLE): dout_spi SHALL equal the registered dout_flat[output_select] with 1-cycle latency, and out_idx SHALL equal the registered output_select.
REQ-004 In direct mode, output_select >= N_CH SHALL give dout_spi = 0.
REQ-005 In direct mode, out_valid SHALL be 0.
REQ-006 The FSM SHALL have the states IDLE, SEND and FIN.
REQ-007 In IDLE with mode=1, snap_req=1 SHALL copy all N_CH channels into a shadow array in the same edge, load ptr=start_ch and go to SEND.
REQ-008 In SEND: out_valid=1, dout_spi=shadow[ptr], out_idx=ptr.
REQ-009 A beat SHALL complete on an edge with out_valid and out_ready both 1; ptr then advances.
REQ-010 dout_spi and out_idx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-011 ptr advance SHALL wrap from N_CH-1 to 0, so start_ch > end_ch scans start..N_CH-1 and then 0..end.
REQ-012 start_ch == end_ch SHALL produce exactly one beat.
REQ-013 start_ch or end_ch >= N_CH at snap_req SHALL be clamped to N_CH-1 at capture.
REQ-014 The beat with ptr == end_ch SHALL move the FSM to FIN.
REQ-015 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-016 busy SHALL be 1 in SEND and FIN only.
REQ-017 snap_req while busy SHALL be ignored.
REQ-018 snap_req in IDLE with mode=0 SHALL be ignored.
REQ-019 start_ch, end_ch and mode SHALL be sampled only at capture; changes during a scan SHALL have no effect.
REQ-020 Live dout_flat changes after capture SHALL NOT affect scan output.
REQ-021 Throughput SHALL be one beat per cycle with out_ready held high.

Reset
REQ-022 rst_n low SHALL force the following regardless of FSM state:
- FSM = IDLE, ptr = 0, shadow = 0.
- dout_spi = 0, out_idx = 0, out_valid = 0, busy = 0, done = 0.
REQ-023 Reset asserted mid-scan SHALL abort the scan with no done pulse.
REQ-024 Reset deassertion SHALL take effect on the first rising clk edge after rst_n goes high.

Structure
REQ-025 The FSM state encoding type and a DATA_W default constant SHALL reside in the shared package ser_grid_pkg.
REQ-026 The wrap-around pointer increment and clamp SHALL be one sub-module, ch_ptr (inputs cur, N_CH param; output nxt).

Verification
REQ-027 Direct mode: N_CH=8, dout_flat channel k = 8'h10+k, output_select=5 -> dout_spi=8'h15 one cycle later, out_valid=0.
REQ-028 Scan: start=2, end=4, out_ready=1, snap_req -> beats 8'h12, 8'h13, 8'h14 on consecutive cycles, then done=1 for one cycle, busy=0 after.
REQ-029 Wrap: start=6, end=1 -> out_idx sequence 6, 7, 0, 1, with dout_flat changed after capture yet shadow values emitted.
REQ-030 Backpressure: out_ready toggles 0/1 every cycle -> each byte held until accepted, no beat lost or duplicated, 3 beats in 6 cycles.
REQ-031 Reset mid-scan: rst_n low after beat 1 -> all outputs 0 immediately, no done, next snap_req restarts from start_ch.
REQ-032 N_CH=6 instance: output_select=7 -> dout_spi=0; start_ch=7 -> clamped to index 5, single beat.
